// File: rtl/midi_tx_ctrl.sv
// MIDI serial transmitter: one-byte holding register (TDR) feeding an 8N1 shifter.
// Frames run back-to-back when the TDR is refilled before the stop bit ends.
module midi_tx_ctrl #(
  parameter int unsigned BAUD_DIV = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       ovr_clr,
  input  logic       irq_en,
  output logic       txd,
  output logic       tdre,
  output logic       busy,
  output logic       ovr,
  output logic       irq
);

  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [7:0]       tdr_q, tdr_d;
  logic             full_q, full_d;
  logic [8:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic             txd_q, txd_d;
  logic             ovr_q, ovr_d;

  logic tick;
  logic load;
  logic accept;
  logic overrun;

  always_comb begin
    tick    = (state_q != StIdle) && (baud_q == BaudMax);
    // A load frees the TDR at the same edge, so a coinciding write is accepted.
    load    = full_q && ((state_q == StIdle) || ((state_q == StStop) && tick));
    accept  = wr && (!full_q || load);
    overrun = wr && full_q && !load;
  end

  always_comb begin
    tdr_d  = tdr_q;
    full_d = full_q;
    if (accept) begin
      tdr_d  = wr_data;
      full_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end
    // A new overrun wins over a simultaneous clear.
    ovr_d = (ovr_q & ~ovr_clr) | overrun;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    baud_d    = baud_q;

    if (state_q == StIdle) begin
      baud_d = '0;
    end else if (tick) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BaudW'(1);
    end

    if (load) begin
      state_d   = StStart;
      shift_d   = {1'b1, tdr_q};
      bit_cnt_d = '0;
      txd_d     = 1'b0;
      baud_d    = '0;
    end else if (tick) begin
      case (state_q)
        StStart: begin
          state_d   = StData;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
        StData: begin
          shift_d = {1'b1, shift_q[8:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
        StStop: begin
          state_d = StIdle;
          txd_d   = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tdr_q     <= '0;
      full_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      txd_q     <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tdr_q     <= tdr_d;
      full_q    <= full_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
      ovr_q     <= ovr_d;
    end
  end

  assign txd  = txd_q;
  assign tdre = ~full_q;
  assign busy = (state_q != StIdle);
  assign ovr  = ovr_q;
  assign irq  = ~full_q & irq_en;

endmodule

// File: tb/tb_midi_tx_ctrl.sv
// Bench for midi_tx_ctrl: frame-timing reference model plus a line decoder on txd.
module tb_midi_tx_ctrl;

  localparam int B = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovr_clr = 1'b0;
  logic       irq_en = 1'b0;
  logic       txd, tdre, busy, ovr, irq;

  midi_tx_ctrl #(.BAUD_DIV(B)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr      (wr),
    .wr_data (wr_data),
    .ovr_clr (ovr_clr),
    .irq_en  (irq_en),
    .txd     (txd),
    .tdre    (tdre),
    .busy    (busy),
    .ovr     (ovr),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: a frame loaded at edge m_l owns the line for 10*B edges.
  int         e = 0;
  int         m_l = 0;
  logic       m_full = 1'b0;
  logic       m_active = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] m_tdr = 8'h00;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_sent[$];

  logic       line_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_b[$];
  int         busy_cnt = 0;
  int         busy_falls = 0;
  logic       prev_busy = 1'b0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = (e - m_l) / B;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic step();
    logic free, ld, ovrn;
    @(negedge clock);
    e++;
    free = !m_active || (e - m_l == 10 * B);
    ld   = free && m_full;
    ovrn = wr && m_full && !ld;
    if (ld) begin
      m_l = e; m_byte = m_tdr; m_active = 1'b1; m_sent.push_back(m_tdr);
    end else if (free) begin
      m_active = 1'b0;
    end
    if (wr && (!m_full || ld)) begin
      m_tdr = wr_data; m_full = 1'b1;
    end else if (ld) begin
      m_full = 1'b0;
    end
    m_ovr = (m_ovr && !ovr_clr) || ovrn;
    @(posedge clock);
    check1("txd", txd, exp_txd());
    check1("busy", busy, m_active);
    check1("tdre", tdre, !m_full);
    check1("ovr", ovr, m_ovr);
    check1("irq", irq, !m_full && irq_en);
    line_q.push_back(txd);
    if (busy) busy_cnt++;
    if (prev_busy && !busy) busy_falls++;
    prev_busy = busy;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr = 1'b1; wr_data = d;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      step(); n++;
    end
    check1("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    m_full = 1'b0; m_active = 1'b0; m_ovr = 1'b0; m_tdr = 8'h00;
    check1("rst_txd", txd, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tdre", tdre, 1'b1);
    check1("rst_ovr", ovr, 1'b0);
    check1("rst_irq", irq, irq_en);
    repeat (3) @(posedge clock);
    reset = 1'b0;
    line_q.delete();
    busy_cnt = 0; busy_falls = 0; prev_busy = 1'b0;
  endtask

  task automatic decode();
    int i = 0;
    logic [7:0] b;
    got_q.delete();
    while (i < line_q.size()) begin
      if (line_q[i] == 1'b0 && i + 10 * B <= line_q.size()) begin
        for (int k = 0; k < 8; k++) b[k] = line_q[i + (k + 1) * B + B / 2];
        got_q.push_back(b);
        i += 10 * B;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_bytes(input string tag);
    decode();
    checkn({tag, "_count"}, got_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_q.size(); i++) checkn(tag, got_q[i], exp_b[i]);
  endtask

  initial begin
    do_reset();

    // Single frame, 0x90
    irq_en = 1'b1;
    write_byte(8'h90);
    check1("wr_tdre", tdre, 1'b0);
    check1("wr_irq", irq, 1'b0);
    step();
    check1("load_tdre", tdre, 1'b1);
    check1("load_txd", txd, 1'b0);
    repeat (45) step();
    checkn("busy40", busy_cnt, 40);
    exp_b = {8'h90};
    check_bytes("frame90");

    // Back-to-back frames, second write mid-frame
    line_q.delete(); busy_cnt = 0; busy_falls = 0;
    write_byte(8'h3C);
    step();
    repeat (8) step();
    write_byte(8'h45);
    wait_idle(200);
    checkn("busy80", busy_cnt, 80);
    checkn("no_gap", busy_falls, 1);
    exp_b = {8'h3C, 8'h45};
    check_bytes("b2b");

    // Write coinciding with load, then an overrun
    line_q.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    check1("no_ovr_on_load", ovr, 1'b0);
    repeat (5) step();
    write_byte(8'h33);
    check1("ovr_set", ovr, 1'b1);
    wait_idle(300);
    exp_b = {8'h11, 8'h22};
    check_bytes("drop33");

    // Overrun clear, and clear colliding with a new overrun
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check1("ovr_clr", ovr, 1'b0);
    write_byte(8'hAA);
    write_byte(8'hBB);
    wr = 1'b1; wr_data = 8'hCC; ovr_clr = 1'b1;
    step();
    wr = 1'b0; ovr_clr = 1'b0;
    check1("ovr_clr_collide", ovr, 1'b1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check1("ovr_clr2", ovr, 1'b0);
    wait_idle(300);

    // Reset during data bit 3 of 0xFF
    write_byte(8'hFF);
    step();
    repeat (4 * B + 1) step();
    check1("mid_bit3", txd, 1'b1);
    do_reset();
    repeat (60) step();
    decode();
    checkn("quiet_after_reset", got_q.size(), 0);

    // Interrupt disabled
    irq_en = 1'b0;
    write_byte(8'h5A);
    check1("irq_off", irq, 1'b0);
    repeat (50) step();

    // Randomized traffic
    line_q.delete(); m_sent.delete();
    for (int n = 0; n < 3000; n++) begin
      wr      = ($urandom_range(0, 29) == 0);
      wr_data = 8'($urandom);
      ovr_clr = ($urandom_range(0, 19) == 0);
      irq_en  = 1'($urandom_range(0, 1));
      step();
    end
    wr = 1'b0; ovr_clr = 1'b0;
    repeat (100) step();
    exp_b = m_sent;
    check_bytes("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
